// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register slave that configures the PWM block.
// Holds frame geometry, register addresses, the control FSM state type and
// the frame acceptance rule used at commit time.
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] REG_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

    // A frame is committed only if it is exactly FRAME_BITS long, is a write
    // (MSB set) and targets an implemented register.
    function automatic logic frame_commits(
        input logic [FRAME_BITS-1:0] frame,
        input logic [CNT_W-1:0]      bit_cnt,
        input logic [ADDR_W-1:0]     max_addr
    );
        return (bit_cnt == CNT_W'(FRAME_BITS)) &&
               frame[FRAME_BITS-1] &&
               (frame[FRAME_BITS-2:DATA_W] <= max_addr);
    endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between a host and the register slave.
//   sclk : serial clock (mode 0, sampled on rising edge)
//   copi : controller-out / peripheral-in data
//   ncs  : active-low chip select framing one transfer
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin with edge pulses.
//   clk, rst_n : system clock, async active-low reset
//   async_in   : raw pin
//   sync_out   : synchronised level (STAGES flops deep)
//   rise, fall : single-cycle pulses from comparing sync_out with its
//                previous value
// RST_VAL sets the level every flop assumes during reset so an idle pin does
// not produce a spurious edge on release.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RST_VAL}};
            prev_r  <= RST_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], async_in};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign sync_out = chain_r[STAGES-1];
    assign rise     = chain_r[STAGES-1] & ~prev_r;
    assign fall     = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register slave feeding the PWM block.
//   clk, rst_n      : system clock, async active-low reset
//   spi (slave)     : sclk / copi / ncs pins, asynchronous to clk
//   en_reg_out_7_0  : reg 0x00, output enables 7:0
//   en_reg_out_15_8 : reg 0x01, output enables 15:8
//   en_reg_pwm_7_0  : reg 0x02, PWM mode enables 7:0
//   en_reg_pwm_15_8 : reg 0x03, PWM mode enables 15:8
//   pwm_duty_cycle  : reg 0x04, shared duty cycle
// Frames are 16 bits MSB first: {write, addr[6:0], data[7:0]}. Anything that
// is not an exact-length write to an implemented address is silently dropped.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_peripheral_if.slave    spi,
    output logic [DATA_W-1:0]  en_reg_out_7_0,
    output logic [DATA_W-1:0]  en_reg_out_15_8,
    output logic [DATA_W-1:0]  en_reg_pwm_7_0,
    output logic [DATA_W-1:0]  en_reg_pwm_15_8,
    output logic [DATA_W-1:0]  pwm_duty_cycle
);

    localparam int               FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic ncs_sync_s, ncs_rise_s, ncs_fall_s;
    logic copi_sync_s, copi_rise_s, copi_fall_s;
    logic unused_edges_s;

    logic [FLUSH_W-1:0]    flush_cnt_r;
    logic                  armed_r;
    spi_state_e            state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_W-1:0]     reg_out_lo_r;
    logic [DATA_W-1:0]     reg_out_hi_r;
    logic [DATA_W-1:0]     reg_pwm_lo_r;
    logic [DATA_W-1:0]     reg_pwm_hi_r;
    logic [DATA_W-1:0]     reg_duty_r;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_in(spi.sclk),
        .sync_out(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .async_in(spi.ncs),
        .sync_out(ncs_sync_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .async_in(spi.copi),
        .sync_out(copi_sync_s), .rise(copi_rise_s), .fall(copi_fall_s)
    );

    // Only the copi level and the sclk rising edge carry meaning here.
    assign unused_edges_s = &{1'b0, sclk_sync_s, sclk_fall_s, copi_rise_s, copi_fall_s};

    // Arming: after reset the ncs synchroniser is preset high, so a pin held
    // low through reset would look like a fresh falling edge. Wait until the
    // chain holds real pin samples and shows nCS high before accepting frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= '0;
            armed_r     <= 1'b0;
        end else if (flush_cnt_r != FLUSH_DONE) begin
            flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
            armed_r     <= 1'b0;
        end else begin
            flush_cnt_r <= flush_cnt_r;
            armed_r     <= armed_r | ncs_sync_s;
        end
    end

    // Frame FSM, shift register, bit counter and the register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            reg_out_lo_r <= 8'h00;
            reg_out_hi_r <= 8'h00;
            reg_pwm_lo_r <= 8'h00;
            reg_pwm_hi_r <= 8'h00;
            reg_duty_r   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (armed_r && ncs_fall_s) begin
                        shift_r   <= '0;
                        bit_cnt_r <= '0;
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SHIFT: begin
                    // End of frame has priority over a coincident sclk edge.
                    if (ncs_rise_s) begin
                        state_r <= COMMIT;
                    end else if (sclk_rise_s && !ncs_sync_s) begin
                        shift_r <= {shift_r[FRAME_BITS-2:0], copi_sync_s};
                        if (bit_cnt_r != 5'd31) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                COMMIT: begin
                    if (frame_commits(shift_r, bit_cnt_r, MAX_ADDR)) begin
                        case (shift_r[FRAME_BITS-2:DATA_W])
                            REG_EN_OUT_LO: reg_out_lo_r <= shift_r[DATA_W-1:0];
                            REG_EN_OUT_HI: reg_out_hi_r <= shift_r[DATA_W-1:0];
                            REG_EN_PWM_LO: reg_pwm_lo_r <= shift_r[DATA_W-1:0];
                            REG_EN_PWM_HI: reg_pwm_hi_r <= shift_r[DATA_W-1:0];
                            REG_DUTY:      reg_duty_r   <= shift_r[DATA_W-1:0];
                            default:       reg_duty_r   <= reg_duty_r;
                        endcase
                    end else begin
                        reg_duty_r <= reg_duty_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign en_reg_out_7_0  = reg_out_lo_r;
    assign en_reg_out_15_8 = reg_out_hi_r;
    assign en_reg_pwm_7_0  = reg_pwm_lo_r;
    assign en_reg_pwm_15_8 = reg_pwm_hi_r;
    assign pwm_duty_cycle  = reg_duty_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral. A reference register model is
// updated whenever a frame ends; the expected register snapshot is queued with
// the cycle by which it must be visible and compared by a monitor process.
module tb_spi_peripheral;

    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    typedef struct {
        int          due;
        logic [39:0] regs;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic [39:0] dut_regs;

    spi_peripheral_if spi_bus ();

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi(spi_bus.slave),
        .en_reg_out_7_0(en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    assign dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    int   cyc        = 0;
    int   cur_off    = 0;
    sb_t  sb_q[$];
    logic [7:0] model [0:4];
    string reg_names [0:4] = '{"out_lo", "out_hi", "pwm_lo", "pwm_hi", "duty"};

    always #5 clk = ~clk;

    // Cycle counter used to timestamp scoreboard deadlines.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [39:0] snapshot();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    // Wait h clk periods, then an optional sub-cycle offset. With h == 2 the
    // offset never shrinks below the previous one, so no phase is shorter
    // than two clk periods.
    task automatic phase(input int h, input bit jit);
        int o;
        o = 0;
        if (jit) begin
            if (h == 2) o = $urandom_range(4, cur_off);
            else        o = $urandom_range(4, 0);
        end
        repeat (h) @(negedge clk);
        #(o);
        cur_off = o;
    endtask

    function automatic int half_len(input bit jit);
        return jit ? int'($urandom_range(4, 2)) : 2;
    endfunction

    task automatic send_bits(input logic [31:0] bits, input int n, input bit jit);
        for (int i = n - 1; i >= 0; i--) begin
            spi_bus.copi = bits[i];
            phase(half_len(jit), jit);
            spi_bus.sclk = 1'b1;
            phase(half_len(jit), jit);
            spi_bus.sclk = 1'b0;
        end
    endtask

    // Called right after nCS rises: update model (if the frame is expected
    // to reach the slave) and queue the expected register image.
    task automatic end_frame(input logic [31:0] bits, input int n, input bit apply);
        sb_t e;
        if (apply && n == 16 && bits[15] && bits[14:8] <= 7'h04)
            model[bits[10:8]] = bits[7:0];
        e.due  = cyc + LATENCY;
        e.regs = snapshot();
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input bit jit);
        phase(2, jit);
        spi_bus.ncs = 1'b0;
        send_bits(bits, n, jit);
        phase(2, jit);
        spi_bus.ncs = 1'b1;
        end_frame(bits, n, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("scoreboard_drain", 8'(sb_q.size()), 8'd0);
    endtask

    // Monitor: compare every queued register image at its deadline.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0 && cyc >= sb_q[0].due) begin
                e = sb_q.pop_front();
                for (int r = 0; r < 5; r++)
                    check_eq($sformatf("frame_%s", reg_names[r]), dut_regs[r*8 +: 8], e.regs[r*8 +: 8]);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        rst_n        = 1'b0;
        for (int r = 0; r < 5; r++) model[r] = 8'h00;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 5; r++)
            check_eq($sformatf("reset_%s", reg_names[r]), dut_regs[r*8 +: 8], 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single write to reg 0.
        send_frame(32'h80F0, 16, 1'b0);
        drain();

        // Back-to-back duty writes with the minimum nCS-high gap.
        send_frame(32'h8480, 16, 1'b0);
        send_frame(32'h84FF, 16, 1'b0);
        drain();

        // Read frame and out-of-range address are dropped.
        send_frame(32'h0255, 16, 1'b0);
        send_frame(32'h8555, 16, 1'b0);
        drain();

        // Truncated and over-long frames are dropped.
        send_frame(32'h0000081A, 12, 1'b0);
        send_frame(32'h000181AA, 17, 1'b0);
        drain();

        // Preload all registers, then reset in the middle of a frame.
        for (int a = 0; a < 5; a++)
            send_frame({16'h0000, 1'b1, 7'(a), 8'h5A}, 16, 1'b0);
        drain();
        phase(2, 1'b0);
        spi_bus.ncs = 1'b0;
        send_bits(32'h00000083, 8, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 5; r++) begin
            model[r] = 8'h00;
            check_eq($sformatf("async_rst_%s", reg_names[r]), dut_regs[r*8 +: 8], 8'h00);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        // nCS was already low at release: these bits must not form a frame.
        send_bits(32'h00008011, 16, 1'b0);
        phase(2, 1'b0);
        spi_bus.ncs = 1'b1;
        end_frame(32'h00008011, 16, 1'b0);
        send_frame(32'h833C, 16, 1'b0);
        drain();

        // Random valid writes with sclk phase jitter.
        cur_off = 0;
        for (int k = 0; k < 100; k++)
            send_frame({16'h0000, 1'b1, 7'($urandom_range(4, 0)), 8'($urandom)}, 16, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI-mode-0 write-only register slave that feeds the PWM peripheral its five 8-bit configuration registers.
- Pins: SCLK, COPI and nCS arrive on dedicated inputs ui_in[0], ui_in[1] and ui_in[2] as asynchronous pins.
- They are synchronised into clk, decoded into 16-bit frames, and committed to a register bank.
- The register bank drives pwm_peripheral directly.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2)
MAX_ADDR, 7'h04, highest valid register address; writes above it are dropped

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sclk  input  1  SPI clock pin (ui_in[0]), asynchronous to clk
copi  input  1  SPI data-in pin (ui_in[1]), asynchronous to clk
ncs  input  1  SPI chip-select pin (ui_in[2]), active-low, asynchronous to clk
en_reg_out_7_0  output  8  reg 0x00: output enables, bits 7:0
en_reg_out_15_8  output  8  reg 0x01: output enables, bits 15:8
en_reg_pwm_7_0  output  8  reg 0x02: PWM mode enables, bits 7:0
en_reg_pwm_15_8  output  8  reg 0x03: PWM mode enables, bits 15:8
pwm_duty_cycle  output  8  reg 0x04: shared duty cycle (0x00 = 0 %, 0xFF = 100 %)

Behaviour:
- Reset: async assert of rst_n clears every stage immediately.
  - All synchroniser flops go to 1 for ncs and to 0 for sclk/copi.
  - Shift register and bit counter go to 0; FSM goes to IDLE; all five outputs go to 8'h00.
  - Deassertion is released synchronously to clk by the top-level reset tree.
- Synchronisers: each pin passes through SYNC_STAGES flops.
  - Edges are detected on the last two synced samples: sclk_rise, ncs_fall, ncs_rise.
- Frame format: MSB first, 16 bits.
  - bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Timing: SPI mode 0, data sampled on sclk rising edge. SCLK high and low phases must each last ≥ 2 clk periods; faster SCLK is unsupported.
- FSM states:
  - IDLE: wait for ncs_fall. Then clear the counter and shift register and go to SHIFT.
  - SHIFT: on each sclk_rise while synced ncs == 0, shift synced copi into bit 0 and increment the 5-bit counter (saturates at 31). On ncs_rise go to COMMIT.
  - COMMIT (one cycle): if counter == 16 and bit15 == 1 and address ≤ MAX_ADDR, write data to the addressed register. Always return to IDLE.
- Latency: register value visible on the clk edge after COMMIT, i.e. SYNC_STAGES+2 clk cycles after the nCS pin rises.
- Discard rules (no register changes; no error output):
  - counter ≠ 16, whether truncated or over-long;
  - read frame (bit15 == 0);
  - address > MAX_ADDR.
- Simultaneous events:
  - sclk_rise in the same cycle as ncs_rise: ncs_rise wins; the bit is not sampled.
  - ncs_fall while in COMMIT: ignored. The host must hold nCS high ≥ 2 clk cycles between frames.
- Reset mid-frame: the frame is lost. After release the FSM waits in IDLE for a fresh ncs_fall, even if nCS is already low.
- Outputs are registered, hold their value between writes, and never glitch on discarded frames.

Decomposition:
- Shared package spi_regs_pkg: address constants REG_EN_OUT_LO=0x00, REG_EN_OUT_HI=0x01, REG_EN_PWM_LO=0x02, REG_EN_PWM_HI=0x03, REG_DUTY=0x04; FRAME_BITS=16; ADDR_W=7; DATA_W=8; FSM state enum (IDLE, SHIFT, COMMIT).
- Sub-module sync_edge_detect: SYNC_STAGES-deep synchroniser plus rise/fall pulse outputs and a configurable reset value. Instantiate it for sclk and ncs; copi uses the synchroniser only.

Test Plan:
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 == 0xF0 within SYNC_STAGES+2 clk of nCS rising; the other four registers stay 0x00.
- Write 0x8480, then write 0x84FF -> pwm_duty_cycle == 0x80 after the first frame and 0xFF after the second; back-to-back frames with a 2-clk nCS-high gap both commit.
- Read frame 0x0255 and write frame 0x8555 (addr 0x05) -> all registers unchanged from their prior values.
- Truncated 12-bit frame and over-long 17-bit frame, each carrying write/addr 0x01/data 0xAA -> en_reg_out_15_8 unchanged.
- Assert rst_n low mid-frame after 8 bits of 0x83.., with registers preloaded to 0x5A -> all outputs 0x00 immediately (asynchronously). After release, a full 0x833C frame -> en_reg_pwm_15_8 == 0x3C.
- Random SCLK phase jitter at the minimum 2-clk half-period across 100 random valid writes -> every register matches a reference model after every frame.
